hps_ext_cmd_rx: RTL and testbench
=================================

# hps_ext_cmd_rx

HPS-to-core command receiver on the MiSTer EXT_BUS, the counterpart to the core-to-HPS status/data reporter. The HPS issues an EXT command word followed by a payload burst; this block claims matching frames, stores the payload in a local word buffer and presents it to core logic as a single pending command with a valid/ack handshake. It sits beside the existing EXT_BUS responder in the top level and only drives the bus when the command word matches `CMD`.

## Interface
- `CMD`, 'h71, EXT command code this block claims.
- `DEPTH`, 128, payload buffer depth in 16-bit words; 1..256.
- `AW`, $clog2(DEPTH), buffer read-address width.

- `clk_sys`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `EXT_BUS`  inout  36  [15:0] io_dout (driven), [31:16] io_din, [32] dout_en (driven), [33] io_strobe, [35:34] io_enable (OR of both bits).
- `cmd_valid`  out  1  a committed frame is pending.
- `cmd_len`  out  9  payload words stored (1..DEPTH).
- `cmd_ovf`  out  1  frame carried more than DEPTH payload words; excess dropped.
- `cmd_seq`  out  8  count of committed frames, wraps 255->0.
- `cmd_ack`  in  1  core has consumed the pending frame.
- `rd_addr`  in  AW  buffer read address.
- `rd_data`  out  16  buffer word at `rd_addr`, registered.

## Operation
- Reset: io_dout=0, dout_en=0, cmd_valid=0, cmd_len=0, cmd_ovf=0, cmd_seq=0, rd_data=0, word_cnt=0, match=0, skip=1 if io_enable high else 0.
- io_enable low: word_cnt=0, io_dout=0, dout_en=0, skip=0; if match was set, frame ends (commit rule below), match cleared.
- skip=1: all strobes ignored until io_enable drops (reset mid-frame never misparses a payload word as a command).
- First strobe of frame (word_cnt=0): match <= (io_din==CMD); dout_en <= same; busy <= cmd_valid; io_dout <= {1'b1, busy, 5'b0, DEPTH[8:0]} when matched, else 0.
- Later strobes with match and !busy: word k (k>=1) written to buffer[k-1] if k<=DEPTH, else ovf flag set; io_dout <= 0.
- word_cnt saturates at 1023; ovf remains set.
- Commit at io_enable falling, with match && !busy && word_cnt>=2: cmd_valid<=1, cmd_len<=min(word_cnt-1,DEPTH), cmd_ovf<=ovf, cmd_seq<=cmd_seq+1.
- Zero-payload frame (only command word) or busy frame: no commit, buffer and outputs untouched.
- cmd_ack while cmd_valid: cmd_valid<=0 next cycle; cmd_len/cmd_ovf hold. cmd_ack while !cmd_valid: ignored.
- busy decided at command word only; ack mid-frame does not rescue a busy frame.
- Buffer is written only while !cmd_valid, so core reads never race writes.

## Timing
- Response word registered on strobe; HPS samples it on its next strobe (same as existing responder).
- rd_data: 1-cycle latency from rd_addr.
- cmd_valid rises 1 cycle after the cycle io_enable is sampled low.
- Commit and ack cannot coincide (commit requires !busy, i.e. cmd_valid was 0 at frame start).
- dout_en high from first-strobe cycle+1 until io_enable low +1.

## Structure
- Shared package `hps_ext_pkg`: EXT_BUS bit-field localparams (DOUT, DIN, DOUT_EN, STROBE, ENABLE ranges), command codes 'h70/'h71, status-word bit positions.
- One sub-module: `hps_ext_dpram` (simple dual-port RAM, 16-bit, write port + registered read port), inferred as block RAM.
- Top level ORs io_dout/dout_en from this block and the reporter; only one claims a given frame.

## Test plan
- Frame CMD='h71 + 3 words 1111/2222/3333 -> status 8080 returned, cmd_valid=1, cmd_len=3, cmd_seq=1, rd_addr 0..2 gives 1111/2222/3333 one cycle later.
- Second frame while cmd_valid=1 -> status C080, buffer unchanged, cmd_seq stays 1; after cmd_ack a third frame commits, cmd_seq=2.
- Frame of 130 payload words with DEPTH=128 -> cmd_len=128, cmd_ovf=1, buffer[127]=word 128.
- Foreign command 'h70 with payload -> dout_en stays 0, io_dout 0, no commit.
- Command-only 'h71 frame -> no commit, cmd_valid stays 0.
- reset asserted after word 2 of a 5-word frame -> outputs reset values, remaining strobes ignored, next clean frame commits normally with cmd_seq=1.

Source files
------------

// File: rtl/hps_ext_pkg.sv
// Shared EXT_BUS definitions: bus bit fields, command codes and the status-word layout.
package hps_ext_pkg;

  localparam int unsigned EXT_W       = 36;
  localparam int unsigned EXT_DOUT_LO = 0;
  localparam int unsigned EXT_DOUT_HI = 15;
  localparam int unsigned EXT_DIN_LO  = 16;
  localparam int unsigned EXT_DIN_HI  = 31;
  localparam int unsigned EXT_DOUT_EN = 32;
  localparam int unsigned EXT_STROBE  = 33;
  localparam int unsigned EXT_ENA_LO  = 34;
  localparam int unsigned EXT_ENA_HI  = 35;

  localparam logic [15:0] EXT_CMD_REPORT = 16'h0070;
  localparam logic [15:0] EXT_CMD_RX     = 16'h0071;

  localparam int unsigned ST_VALID_BIT = 15;
  localparam int unsigned ST_BUSY_BIT  = 14;
  localparam int unsigned ST_DEPTH_W   = 9;

  localparam int unsigned WCNT_W = 10;
  localparam int unsigned LEN_W  = 9;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_SKIP,
    RX_RECV,
    RX_BUSY,
    RX_FOREIGN
  } rx_state_t;

  // Response word returned on the command strobe.
  function automatic logic [15:0] status_word(input logic busy, input logic [ST_DEPTH_W-1:0] depth);
    logic [15:0] w;
    w                  = '0;
    w[ST_VALID_BIT]    = 1'b1;
    w[ST_BUSY_BIT]     = busy;
    w[ST_DEPTH_W-1:0]  = depth;
    return w;
  endfunction

endpackage

// File: rtl/hps_ext_cmd_rx_if.sv
// EXT_BUS split into the HPS-driven bits and the core-driven response.
interface hps_ext_cmd_rx_if;
  import hps_ext_pkg::*;

  logic [EXT_W-1:0] ext_in;
  logic [15:0]      io_dout;
  logic             dout_en;

  modport master (output ext_in, input io_dout, input dout_en);
  modport slave  (input ext_in, output io_dout, output dout_en);

endinterface

// File: rtl/hps_ext_dpram.sv
// Simple dual-port 16-bit RAM: one write port, one registered read port.
module hps_ext_dpram #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_rdata <= '0;
    else         r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/hps_ext_cmd_rx.sv
// HPS-to-core command receiver: claims CMD frames on EXT_BUS, buffers the payload
// and presents it as one pending command with a valid/ack handshake.
module hps_ext_cmd_rx
  import hps_ext_pkg::*;
#(
  parameter logic [15:0] CMD   = EXT_CMD_RX,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   i_clk_sys,
  input  logic                   i_reset,
  hps_ext_cmd_rx_if.slave        ext,
  output logic                   o_cmd_valid,
  output logic [LEN_W-1:0]       o_cmd_len,
  output logic                   o_cmd_ovf,
  output logic [7:0]             o_cmd_seq,
  input  logic                   i_cmd_ack,
  input  logic [AW-1:0]          i_rd_addr,
  output logic [15:0]            o_rd_data
);

  localparam logic [WCNT_W-1:0] WCNT_MAX  = '1;
  localparam logic [WCNT_W-1:0] DEPTH_CNT = WCNT_W'(DEPTH);

  rx_state_t         r_state, w_state_d;
  logic [WCNT_W-1:0] r_cnt, w_cnt_d;
  logic              r_ovf, w_ovf_d;
  logic [15:0]       r_dout, w_dout_d;
  logic              r_dout_en, w_dout_en_d;
  logic              r_valid, w_valid_d;
  logic [LEN_W-1:0]  r_len, w_len_d;
  logic              r_cmd_ovf, w_cmd_ovf_d;
  logic [7:0]        r_seq, w_seq_d;

  logic              w_en, w_stb, w_we;
  logic [15:0]       w_din;
  logic [AW-1:0]     w_waddr;
  logic [WCNT_W-1:0] w_cnt_inc, w_payload;
  logic              w_unused;

  assign w_en      = |ext.ext_in[EXT_ENA_HI:EXT_ENA_LO];
  assign w_stb     = ext.ext_in[EXT_STROBE];
  assign w_din     = ext.ext_in[EXT_DIN_HI:EXT_DIN_LO];
  assign w_unused  = &{1'b0, ext.ext_in[EXT_DOUT_HI:EXT_DOUT_LO], ext.ext_in[EXT_DOUT_EN]};
  assign w_cnt_inc = (r_cnt == WCNT_MAX) ? r_cnt : r_cnt + WCNT_W'(1);
  assign w_payload = r_cnt - WCNT_W'(1);
  assign w_waddr   = AW'(w_payload);

  // Frame parsing, commit and ack handling.
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_ovf_d     = r_ovf;
    w_dout_d    = r_dout;
    w_dout_en_d = r_dout_en;
    w_valid_d   = r_valid;
    w_len_d     = r_len;
    w_cmd_ovf_d = r_cmd_ovf;
    w_seq_d     = r_seq;
    w_we        = 1'b0;

    if (r_valid && i_cmd_ack) w_valid_d = 1'b0;

    if (!w_en) begin
      w_state_d   = RX_IDLE;
      w_cnt_d     = '0;
      w_ovf_d     = 1'b0;
      w_dout_d    = '0;
      w_dout_en_d = 1'b0;
      if (r_state == RX_RECV && r_cnt >= WCNT_W'(2)) begin
        w_valid_d   = 1'b1;
        w_len_d     = (w_payload > DEPTH_CNT) ? LEN_W'(DEPTH) : LEN_W'(w_payload);
        w_cmd_ovf_d = r_ovf;
        w_seq_d     = r_seq + 8'd1;
      end
    end else if (w_stb) begin
      unique case (r_state)
        RX_IDLE: begin
          w_cnt_d = WCNT_W'(1);
          w_ovf_d = 1'b0;
          if (w_din == CMD) begin
            w_dout_en_d = 1'b1;
            w_dout_d    = status_word(r_valid, ST_DEPTH_W'(DEPTH));
            w_state_d   = r_valid ? RX_BUSY : RX_RECV;
          end else begin
            w_dout_en_d = 1'b0;
            w_dout_d    = '0;
            w_state_d   = RX_FOREIGN;
          end
        end
        RX_RECV: begin
          w_dout_d = '0;
          w_cnt_d  = w_cnt_inc;
          if (r_cnt <= DEPTH_CNT) w_we    = !r_valid;
          else                    w_ovf_d = 1'b1;
        end
        RX_BUSY, RX_FOREIGN: begin
          w_dout_d = '0;
          w_cnt_d  = w_cnt_inc;
        end
        default: ;
      endcase
    end
  end

  // A reset that lands mid-frame parks in RX_SKIP until io_enable drops.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_state   <= w_en ? RX_SKIP : RX_IDLE;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_dout    <= '0;
      r_dout_en <= 1'b0;
      r_valid   <= 1'b0;
      r_len     <= '0;
      r_cmd_ovf <= 1'b0;
      r_seq     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_ovf     <= w_ovf_d;
      r_dout    <= w_dout_d;
      r_dout_en <= w_dout_en_d;
      r_valid   <= w_valid_d;
      r_len     <= w_len_d;
      r_cmd_ovf <= w_cmd_ovf_d;
      r_seq     <= w_seq_d;
    end
  end

  hps_ext_dpram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .i_clk   (i_clk_sys),
    .i_reset (i_reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_din),
    .i_raddr (i_rd_addr),
    .o_rdata (o_rd_data)
  );

  assign ext.io_dout  = r_dout;
  assign ext.dout_en  = r_dout_en;
  assign o_cmd_valid  = r_valid;
  assign o_cmd_len    = r_len;
  assign o_cmd_ovf    = r_cmd_ovf;
  assign o_cmd_seq    = r_seq;

endmodule

// File: tb/tb_hps_ext_cmd_rx.sv
// Directed bench for hps_ext_cmd_rx with a small reference model and response/read queues.
module tb_hps_ext_cmd_rx;
  import hps_ext_pkg::*;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;
  localparam logic [15:0] CMD   = EXT_CMD_RX;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    enable;
  logic          strobe;
  logic [15:0]   din;
  logic          cmd_ack;
  logic [AW-1:0] rd_addr;
  logic          cmd_valid;
  logic [8:0]    cmd_len;
  logic          cmd_ovf;
  logic [7:0]    cmd_seq;
  logic [15:0]   rd_data;

  hps_ext_cmd_rx_if bus ();
  assign bus.ext_in = {enable, strobe, 1'b0, din, 16'h0000};

  hps_ext_cmd_rx #(
    .CMD   (CMD),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .i_clk_sys   (clk),
    .i_reset     (reset),
    .ext         (bus),
    .o_cmd_valid (cmd_valid),
    .o_cmd_len   (cmd_len),
    .o_cmd_ovf   (cmd_ovf),
    .o_cmd_seq   (cmd_seq),
    .i_cmd_ack   (cmd_ack),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model of the committed-command state and the payload buffer.
  logic        m_valid, m_ovf;
  logic [8:0]  m_len;
  logic [7:0]  m_seq;
  logic [15:0] m_buf [DEPTH];
  logic        fm_match, fm_busy, fm_skip, fm_ovf;
  int          fm_cnt;
  logic [15:0] q_status [$];
  logic [15:0] q_rd [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_cmd(input string tag);
    chk({tag, "_valid"}, 32'(cmd_valid), 32'(m_valid));
    chk({tag, "_len"},   32'(cmd_len),   32'(m_len));
    chk({tag, "_ovf"},   32'(cmd_ovf),   32'(m_ovf));
    chk({tag, "_seq"},   32'(cmd_seq),   32'(m_seq));
  endtask

  task automatic frame_start(input logic [15:0] cmd, input logic [1:0] ena);
    enable = ena;
    @(negedge clk);
    din      = cmd;
    strobe   = 1'b1;
    fm_cnt   = 1;
    fm_match = (cmd == CMD);
    fm_busy  = m_valid;
    fm_ovf   = 1'b0;
    if (fm_match) q_status.push_back({1'b1, m_valid, 5'b0, 9'(DEPTH)});
    @(negedge clk);
    strobe = 1'b0;
    chk("hdr_dout_en", 32'(bus.dout_en), 32'(fm_match));
    if (fm_match) chk("hdr_status", 32'(bus.io_dout), 32'(q_status.pop_front()));
    else          chk("hdr_dout_zero", 32'(bus.io_dout), 32'd0);
  endtask

  task automatic frame_word(input logic [15:0] w);
    din    = w;
    strobe = 1'b1;
    if (!fm_skip) begin
      if (fm_match && !fm_busy) begin
        if (fm_cnt <= DEPTH) m_buf[fm_cnt-1] = w;
        else                 fm_ovf = 1'b1;
      end
      if (fm_cnt < 1023) fm_cnt++;
    end
    @(negedge clk);
    strobe = 1'b0;
    chk("pay_dout", 32'(bus.io_dout), 32'd0);
    chk("pay_dout_en", 32'(bus.dout_en), 32'(fm_match));
  endtask

  task automatic frame_end(input string tag);
    enable = 2'b00;
    @(negedge clk);
    if (!fm_skip && fm_match && !fm_busy && fm_cnt >= 2) begin
      m_valid = 1'b1;
      m_len   = (fm_cnt - 1 > DEPTH) ? 9'(DEPTH) : 9'(fm_cnt - 1);
      m_ovf   = fm_ovf;
      m_seq   = m_seq + 8'd1;
    end
    fm_match = 1'b0;
    fm_skip  = 1'b0;
    chk({tag, "_end_dout_en"}, 32'(bus.dout_en), 32'd0);
    chk({tag, "_end_dout"},    32'(bus.io_dout), 32'd0);
    chk_cmd(tag);
  endtask

  task automatic ack_pulse(input string tag);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    m_valid = 1'b0;
    chk_cmd(tag);
  endtask

  task automatic rd_chk(input int a);
    rd_addr = AW'(a);
    q_rd.push_back(m_buf[a]);
    @(negedge clk);
    chk($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(q_rd.pop_front()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 2'b00; strobe = 1'b0; din = '0; cmd_ack = 1'b0; rd_addr = '0;
    m_valid = 1'b0; m_ovf = 1'b0; m_len = '0; m_seq = '0;
    fm_match = 1'b0; fm_busy = 1'b0; fm_skip = 1'b0; fm_ovf = 1'b0; fm_cnt = 0;
    repeat (3) @(negedge clk);
    chk_cmd("reset");
    chk("reset_dout", 32'(bus.io_dout), 32'd0);
    chk("reset_dout_en", 32'(bus.dout_en), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Command-only frame: claimed but no commit.
    frame_start(CMD, 2'b01);
    frame_end("cmd_only");

    // Foreign command with payload: never claimed.
    frame_start(EXT_CMD_REPORT, 2'b01);
    frame_word(16'h7777); frame_word(16'h8888); frame_word(16'h9999);
    frame_end("foreign");

    // Basic three-word frame.
    frame_start(CMD, 2'b01);
    frame_word(16'h1111); frame_word(16'h2222); frame_word(16'h3333);
    frame_end("basic");
    for (int i = 0; i < 3; i++) rd_chk(i);

    // Busy frame with an ack mid-frame: still dropped.
    frame_start(CMD, 2'b10);
    frame_word(16'hAAAA);
    ack_pulse("mid_ack");
    frame_word(16'hBBBB);
    frame_end("busy");
    for (int i = 0; i < 3; i++) rd_chk(i);
    ack_pulse("idle_ack");

    // Third frame commits after the ack.
    frame_start(CMD, 2'b10);
    frame_word(16'h4444); frame_word(16'h5555);
    frame_end("third");
    rd_chk(0); rd_chk(1);
    ack_pulse("ack3");

    // Overflow: 130 payload words into a 128-word buffer.
    frame_start(CMD, 2'b11);
    for (int i = 1; i <= 130; i++) frame_word(16'h4000 + 16'(i));
    frame_end("ovf");
    rd_chk(0); rd_chk(126); rd_chk(127);
    ack_pulse("ack_ovf");

    // Reset after word 2 of a 5-word frame, then a clean frame.
    frame_start(CMD, 2'b01);
    frame_word(16'h5101);
    reset = 1'b1;
    @(negedge clk);
    m_valid = 1'b0; m_len = '0; m_ovf = 1'b0; m_seq = '0;
    fm_skip = 1'b1; fm_match = 1'b0;
    chk_cmd("midreset");
    chk("midreset_dout", 32'(bus.io_dout), 32'd0);
    chk("midreset_dout_en", 32'(bus.dout_en), 32'd0);
    chk("midreset_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    frame_word(CMD); frame_word(16'h5103); frame_word(16'h5104);
    frame_end("skip");
    frame_start(CMD, 2'b11);
    frame_word(16'h6001); frame_word(16'h6002);
    frame_end("after_reset");
    rd_chk(0); rd_chk(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
